// File: rtl/dmem_arbiter_rr.sv
// Round-robin arbiter sharing one single-port synchronous data memory among
// NUM_CORES cores; one transaction in flight, each runs to completion.
module dmem_arbiter_rr #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES-1:0]          we,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  input  logic [NUM_CORES*DATA_W-1:0]   wdata,
  output logic [NUM_CORES-1:0]          done,
  output logic [DATA_W-1:0]             rdata,
  output logic [NUM_CORES-1:0]          grant,
  output logic                          busy,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_wren,
  input  logic [DATA_W-1:0]             mem_q
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state_q;
  logic [PW-1:0]           ptr_q;
  logic [CW-1:0]           cnt_q;
  logic                    we_q;
  logic [NUM_CORES-1:0]    grant_q, done_q;
  logic [DATA_W-1:0]       rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0]       mem_addr_q;
  logic                    mem_wren_q, busy_q;

  logic [ADDR_W-1:0]       addr_a  [NUM_CORES];
  logic [DATA_W-1:0]       wdata_a [NUM_CORES];

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
    assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = wdata[i*DATA_W +: DATA_W];
  end

  // Winner: lowest requester at or above ptr, else lowest requester overall.
  logic [NUM_CORES-1:0] hi_mask, cand;
  logic [PW-1:0]        win, ptr_nxt;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_CORES; i++) hi_mask[i] = (PW'(i) >= ptr_q);
    cand = (|(req & hi_mask)) ? (req & hi_mask) : req;
    win  = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) if (cand[i]) win = PW'(i);
    ptr_nxt = (win == PW'(NUM_CORES - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            mem_addr_q  <= addr_a[win];
            mem_wdata_q <= wdata_a[win];
            we_q        <= we[win];
            mem_wren_q  <= we[win];
            grant_q     <= NUM_CORES'(1) << win;
            ptr_q       <= ptr_nxt;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_wren_q <= 1'b0;
          if (we_q) begin
            done_q  <= grant_q;
            state_q <= RESP;
          end else begin
            cnt_q   <= CW'(MEM_LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // mem_q is valid exactly in the last WAIT cycle
          if (cnt_q == '0) begin
            rdata_q <= mem_q;
            done_q  <= grant_q;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign rdata     = rdata_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wren  = mem_wren_q;

endmodule

// File: tb/tb_dmem_arbiter_rr.sv
// Bench for dmem_arbiter_rr: random core agents, a latency-MEM_LAT memory,
// and a transaction-level reference predicting every output each cycle.
module tb_dmem_arbiter_rr;
  localparam int NC = 4, AW = 16, DW = 16, LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     req, we, done, grant;
  logic [NC*AW-1:0]  addr;
  logic [NC*DW-1:0]  wdata;
  logic [DW-1:0]     rdata, mem_wdata, mem_q;
  logic [AW-1:0]     mem_addr;
  logic              mem_wren, busy;

  dmem_arbiter_rr #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .done(done), .rdata(rdata), .grant(grant), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Memory: low address byte selects the word; read data appears LAT cycles later.
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] dpipe   [LAT];

  always @(posedge clk) begin
    dpipe[0] <= mem[mem_addr[7:0]];
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    if (mem_wren) mem[mem_addr[7:0]] <= mem_wdata;
  end
  assign mem_q = dpipe[LAT-1];

  // Core agents
  logic          a_req [NC];
  logic          a_we  [NC];
  logic [AW-1:0] a_addr[NC];
  logic [DW-1:0] a_wd  [NC];

  // Reference: current transaction, offset k within it, length L
  bit            m_act, m_we;
  int            m_k, m_L, m_g, m_ptr, cyc;
  logic [AW-1:0] m_addr, h_addr;
  logic [DW-1:0] m_wd, m_rval, h_wdata, h_rdata;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      req[i]              = a_req[i];
      we[i]               = a_we[i];
      addr[i*AW +: AW]    = a_addr[i];
      wdata[i*DW +: DW]   = a_wd[i];
    end
  endtask

  task automatic new_req(input int i);
    a_req[i]  = 1'b1;
    a_we[i]   = 1'($urandom);
    a_addr[i] = {8'($urandom), 8'($urandom_range(0, 15))};
    a_wd[i]   = 16'($urandom);
  endtask

  // Called at each negedge: check this cycle, then drive inputs for it.
  task automatic step(input bit rst_nxt, input bit rnd);
    logic [NC-1:0] e_grant, e_done;
    logic          e_busy, e_wren;
    logic [DW-1:0] e_rdata;
    bit            idle_now, found;
    int            g;
    idle_now = !m_act;
    e_grant = '0; e_done = '0; e_busy = 1'b0; e_wren = 1'b0; e_rdata = h_rdata;
    if (m_act && m_k >= 1) begin
      e_grant[m_g] = 1'b1;
      e_busy       = 1'b1;
      e_wren       = (m_k == 1) && m_we;
      if (m_k == m_L - 1) begin
        e_done[m_g] = 1'b1;
        if (!m_we) e_rdata = m_rval;
      end
    end
    chk("grant",     64'(grant),     64'(e_grant));
    chk("done",      64'(done),      64'(e_done));
    chk("busy",      64'(busy),      64'(e_busy));
    chk("mem_wren",  64'(mem_wren),  64'(e_wren));
    chk("rdata",     64'(rdata),     64'(e_rdata));
    chk("mem_addr",  64'(mem_addr),  64'(h_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(h_wdata));

    if (m_act && m_k == m_L - 1) begin
      m_act = 1'b0;
      if (!m_we) h_rdata = m_rval;
    end
    for (int i = 0; i < NC; i++) begin
      if (e_done[i]) a_req[i] = 1'b0;
      else if (!a_req[i] && rnd && $urandom_range(0, 2) == 0) new_req(i);
    end
    drive();
    rst = rst_nxt;

    if (rst_nxt) begin
      m_act = 1'b0; m_ptr = 0; h_addr = '0; h_wdata = '0; h_rdata = '0;
    end else if (idle_now) begin
      found = 1'b0; g = 0;
      for (int j = 0; j < NC; j++)
        if (!found && a_req[(m_ptr + j) % NC]) begin found = 1'b1; g = (m_ptr + j) % NC; end
      if (found) begin
        m_act = 1'b1; m_k = 0; m_g = g;
        m_we = a_we[g]; m_addr = a_addr[g]; m_wd = a_wd[g];
        m_L = m_we ? 3 : LAT + 3;
        m_ptr = (g + 1) % NC;
        h_addr = m_addr; h_wdata = m_wd;
        if (m_we) ref_mem[m_addr[7:0]] = m_wd;
        else      m_rval = ref_mem[m_addr[7:0]];
      end
    end
    if (m_act) m_k++;
    cyc++;
  endtask

  initial begin
    bit ab;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'(i * 40503) ^ 16'hC35A;
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 16'h1234; ref_mem[8'h10] = 16'h1234;
    for (int i = 0; i < LAT; i++) dpipe[i] = '0;
    m_act = 1'b0; m_we = 1'b0; m_k = 0; m_L = 0; m_g = 0; m_ptr = 0; cyc = 0;
    m_addr = '0; m_wd = '0; m_rval = '0; h_addr = '0; h_wdata = '0; h_rdata = '0;
    for (int i = 0; i < NC; i++) begin
      new_req(i);
      a_req[i] = 1'($urandom);
    end
    drive();
    rst = 1'b1;

    // Reset with random requests pending, then drain them
    @(negedge clk); step(1'b1, 1'b0);
    @(negedge clk); step(1'b0, 1'b0);
    repeat (30) begin @(negedge clk); step(1'b0, 1'b0); end

    // All four cores read distinct addresses at once
    for (int i = 0; i < NC; i++) begin
      a_req[i] = 1'b1; a_we[i] = 1'b0; a_addr[i] = 16'h0020 + 16'(i); a_wd[i] = '0;
    end
    repeat (30) begin @(negedge clk); step(1'b0, 1'b0); end

    // Core 2 reads 0x0010, core 1 writes 0xBEEF to 0x0042, then reads it back
    a_req[2] = 1'b1; a_we[2] = 1'b0; a_addr[2] = 16'h0010;
    repeat (10) begin @(negedge clk); step(1'b0, 1'b0); end
    a_req[1] = 1'b1; a_we[1] = 1'b1; a_addr[1] = 16'h0042; a_wd[1] = 16'hBEEF;
    repeat (6) begin @(negedge clk); step(1'b0, 1'b0); end
    a_req[1] = 1'b1; a_we[1] = 1'b0; a_addr[1] = 16'h0042;
    repeat (10) begin @(negedge clk); step(1'b0, 1'b0); end

    // Random traffic with occasional reset during a read's WAIT phase
    repeat (3000) begin
      @(negedge clk);
      ab = m_act && !m_we && m_k >= 2 && m_k <= LAT + 1 && $urandom_range(0, 19) == 0;
      step(ab, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
